// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg: shared constants and helpers for the scoreboarded register file.
//   DW_DEF / AW_DEF : default data and address widths
//   is_writable()   : register writability test (r0 is hardwired to zero when zero_r0 is set)
package regfile_sb_pkg;

    localparam int DW_DEF = 32;
    localparam int AW_DEF = 5;

    function automatic logic is_writable(input int r, input logic zero_r0);
        return !(zero_r0 && (r == 0));
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: read, writeback and issue signals of the scoreboarded register file.
//   master : drives read addresses, writeback and issue requests
//   slave  : returns read data, stall, iss_fire and n_pending
interface regfile_sb_if
    import regfile_sb_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) ();

    logic [AW-1:0] rR1;
    logic [AW-1:0] rR2;
    logic [DW-1:0] rD1;
    logic [DW-1:0] rD2;
    logic          we;
    logic [AW-1:0] wR;
    logic [DW-1:0] wD;
    logic          iss_valid;
    logic          iss_wen;
    logic [AW-1:0] iss_rd;
    logic          stall;
    logic          iss_fire;
    logic [AW:0]   n_pending;

    modport master (
        output rR1, rR2, we, wR, wD, iss_valid, iss_wen, iss_rd,
        input  rD1, rD2, stall, iss_fire, n_pending
    );

    modport slave (
        input  rR1, rR2, we, wR, wD, iss_valid, iss_wen, iss_rd,
        output rD1, rD2, stall, iss_fire, n_pending
    );

endinterface

// File: rtl/regfile_sb_busy.sv
// sb_busy: per-register busy bits plus a running count of busy registers.
//   clk, rst_n        : clock, async active-low reset
//   set_en, set_idx   : mark a register busy (wins over a same-cycle clear)
//   clr_en, clr_idx   : mark a register done
//   busy              : busy bit per register
//   count             : number of busy registers
module sb_busy #(
    parameter int AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [AW-1:0]     set_idx,
    input  logic              clr_en,
    input  logic [AW-1:0]     clr_idx,
    output logic [2**AW-1:0]  busy,
    output logic [AW:0]       count
);

    localparam logic [AW:0] ONE = (AW + 1)'(1);

    logic [2**AW-1:0] busy_nxt;
    logic [AW:0]      count_nxt;
    logic             inc;
    logic             dec;

    // The count tracks real bit transitions, so a clear of an idle register
    // or a set+clear on the same busy register leaves it unchanged.
    always_comb begin
        busy_nxt = busy;
        if (clr_en) busy_nxt[clr_idx] = 1'b0;
        if (set_en) busy_nxt[set_idx] = 1'b1;
        inc = set_en & ~busy[set_idx];
        dec = clr_en & busy[clr_idx] & ~(set_en && (set_idx == clr_idx));
        count_nxt = count;
        if (inc && !dec)      count_nxt = count + ONE;
        else if (dec && !inc) count_nxt = count - ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= '0;
            count <= '0;
        end else begin
            busy  <= busy_nxt;
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: two-read / one-write register file with write-through bypass and
// a busy-bit scoreboard that stalls issue on RAW and WAW hazards.
//   clk, rst_n : clock, async active-low reset
//   bus        : regfile_sb_if slave (reads, writeback, issue, stall, n_pending)
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int AW      = AW_DEF,
    parameter int ZERO_R0 = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_sb_if.slave  bus
);

    localparam int   NREG = 2**AW;
    localparam logic Z0   = (ZERO_R0 != 0);

    logic [DW-1:0]   mem [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] wr_mask;
    logic [NREG-1:0] effbusy;
    logic            wr_ok;
    logic            set_ok;

    // Writes to a hardwired-zero r0 are dropped here, so neither the array
    // nor the scoreboard ever sees them.
    assign wr_ok = bus.we && is_writable(int'(bus.wR), Z0);

    always_comb begin
        wr_mask = '0;
        if (wr_ok) wr_mask[bus.wR] = 1'b1;
    end

    // A register being written back this cycle no longer blocks issue.
    assign effbusy = busy & ~wr_mask;

    assign bus.stall = bus.iss_valid &
                       (effbusy[bus.rR1] | effbusy[bus.rR2] |
                        (bus.iss_wen & effbusy[bus.iss_rd]));
    assign bus.iss_fire = bus.iss_valid & ~bus.stall;

    assign set_ok = bus.iss_fire & bus.iss_wen & is_writable(int'(bus.iss_rd), Z0);

    assign bus.rD1 = !is_writable(int'(bus.rR1), Z0)  ? '0     :
                     (wr_ok && (bus.wR == bus.rR1)) ? bus.wD : mem[bus.rR1];
    assign bus.rD2 = !is_writable(int'(bus.rR2), Z0)  ? '0     :
                     (wr_ok && (bus.wR == bus.rR2)) ? bus.wD : mem[bus.rR2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[bus.wR] <= bus.wD;
        end
    end

    sb_busy #(.AW(AW)) u_sb_busy (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (set_ok),
        .set_idx (bus.iss_rd),
        .clr_en  (wr_ok),
        .clr_idx (bus.wR),
        .busy    (busy),
        .count   (bus.n_pending)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard bench for regfile_sb, default build (DW=32, AW=5)
// and a wide/shallow build (DW=64, AW=3).
module tb_regfile_sb;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_sb_if #(.DW(32), .AW(5)) ia ();
    regfile_sb_if #(.DW(64), .AW(3)) ib ();

    regfile_sb #(.DW(32), .AW(5), .ZERO_R0(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    regfile_sb #(.DW(64), .AW(3), .ZERO_R0(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    typedef enum int {A_RD1, A_RD2, A_STALL, A_FIRE, A_NP, B_RD1, B_RD2, B_NP} sel_t;
    typedef struct {
        string       tag;
        sel_t        sel;
        logic [63:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, want);
        end
    endtask

    function automatic logic [63:0] obs(input sel_t s);
        case (s)
            A_RD1:   return 64'(ia.rD1);
            A_RD2:   return 64'(ia.rD2);
            A_STALL: return 64'(ia.stall);
            A_FIRE:  return 64'(ia.iss_fire);
            A_NP:    return 64'(ia.n_pending);
            B_RD1:   return ib.rD1;
            B_RD2:   return ib.rD2;
            B_NP:    return 64'(ib.n_pending);
            default: return 64'hx;
        endcase
    endfunction

    task automatic expect_v(input string tag, input sel_t s, input logic [63:0] v);
        exp_t e;
        e.tag = tag; e.sel = s; e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, obs(e.sel), e.val);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        drain();
    endtask

    task automatic idle_a();
        ia.rR1 = '0; ia.rR2 = '0; ia.we = 1'b0; ia.wR = '0; ia.wD = '0;
        ia.iss_valid = 1'b0; ia.iss_wen = 1'b0; ia.iss_rd = '0;
    endtask

    task automatic idle_b();
        ib.rR1 = '0; ib.rR2 = '0; ib.we = 1'b0; ib.wR = '0; ib.wD = '0;
        ib.iss_valid = 1'b0; ib.iss_wen = 1'b0; ib.iss_rd = '0;
    endtask

    task automatic issue_a(input int rd);
        ia.iss_valid = 1'b1; ia.iss_wen = 1'b1; ia.iss_rd = 5'(rd);
    endtask

    initial begin
        idle_a();
        idle_b();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;

        // writes and issues during reset must be ignored
        ia.we = 1'b1; ia.wR = 5'd4; ia.wD = 32'h55; issue_a(3); ia.rR1 = 5'd3;
        expect_v("rst_stall", A_STALL, 0);
        expect_v("rst_fire", A_FIRE, 1);
        expect_v("rst_np", A_NP, 0);
        settle();
        cyc();
        expect_v("rst_stall2", A_STALL, 0);
        expect_v("rst_np2", A_NP, 0);
        expect_v("rst_rd_r4", A_RD1, 0);
        settle();
        idle_a();
        rst_n = 1'b1;
        cyc();

        for (int r = 1; r < 32; r++) begin
            ia.rR1 = 5'(r); ia.rR2 = 5'(31 - r + 1);
            expect_v($sformatf("init_rd1_r%0d", r), A_RD1, 0);
            expect_v($sformatf("init_rd2_r%0d", 32 - r), A_RD2, 0);
            settle();
            cyc();
        end
        expect_v("init_np", A_NP, 0);
        expect_v("init_stall", A_STALL, 0);
        settle();

        // RAW on r5 cleared by same-cycle writeback with bypass
        cyc();
        issue_a(5);
        expect_v("raw_c0_fire", A_FIRE, 1);
        settle();
        cyc();
        ia.iss_wen = 1'b0; ia.rR1 = 5'd5; ia.rR2 = 5'd5;
        expect_v("raw_c1_stall", A_STALL, 1);
        expect_v("raw_c1_fire", A_FIRE, 0);
        expect_v("raw_c1_np", A_NP, 1);
        settle();
        cyc();
        ia.we = 1'b1; ia.wR = 5'd5; ia.wD = 32'hDEADBEEF;
        expect_v("raw_c2_stall", A_STALL, 0);
        expect_v("raw_c2_byp1", A_RD1, 32'hDEADBEEF);
        expect_v("raw_c2_byp2", A_RD2, 32'hDEADBEEF);
        settle();
        cyc();
        idle_a(); ia.rR1 = 5'd5;
        expect_v("raw_c3_arr", A_RD1, 32'hDEADBEEF);
        expect_v("raw_c3_np", A_NP, 0);
        settle();

        // r0 hardwired to zero, never busy
        cyc();
        ia.we = 1'b1; ia.wR = 5'd0; ia.wD = 32'h1234; ia.rR1 = 5'd0;
        expect_v("r0_wr_cyc", A_RD1, 0);
        settle();
        cyc();
        ia.we = 1'b0; issue_a(0);
        expect_v("r0_next", A_RD1, 0);
        expect_v("r0_np", A_NP, 0);
        settle();
        cyc();
        idle_a();
        expect_v("r0_issue_np", A_NP, 0);
        settle();

        // writeback and re-issue of r7 in the same cycle: set wins
        cyc();
        issue_a(7);
        settle();
        cyc();
        idle_a();
        expect_v("waw_np_before", A_NP, 1);
        settle();
        cyc();
        ia.we = 1'b1; ia.wR = 5'd7; ia.wD = 32'h77; issue_a(7); ia.rR1 = 5'd7;
        expect_v("waw_same_stall", A_STALL, 0);
        expect_v("waw_same_byp", A_RD1, 32'h77);
        settle();
        cyc();
        idle_a(); ia.iss_valid = 1'b1; ia.rR1 = 5'd7;
        expect_v("waw_busy7", A_STALL, 1);
        expect_v("waw_np_after", A_NP, 1);
        settle();
        cyc();
        idle_a(); ia.we = 1'b1; ia.wR = 5'd7; ia.wD = 32'h78;
        settle();
        cyc();
        idle_a(); ia.rR1 = 5'd7;
        expect_v("wb7_np", A_NP, 0);
        expect_v("wb7_rd", A_RD1, 32'h78);
        settle();

        // writeback to an idle register must not decrement the count
        cyc();
        issue_a(10);
        settle();
        cyc();
        idle_a(); ia.we = 1'b1; ia.wR = 5'd9; ia.wD = 32'h99;
        settle();
        cyc();
        idle_a(); ia.rR1 = 5'd9;
        expect_v("idle_wb_np", A_NP, 1);
        expect_v("idle_wb_rd", A_RD1, 32'h99);
        settle();
        cyc();
        ia.we = 1'b1; ia.wR = 5'd10; ia.wD = 32'hA; issue_a(12);
        expect_v("swap_fire", A_FIRE, 1);
        settle();
        cyc();
        idle_a(); ia.iss_valid = 1'b1; ia.rR2 = 5'd12;
        expect_v("swap_np", A_NP, 1);
        expect_v("swap_stall12", A_STALL, 1);
        settle();
        cyc();
        idle_a(); ia.we = 1'b1; ia.wR = 5'd12; ia.wD = 32'hC;
        settle();
        cyc();
        idle_a();
        expect_v("swap_np_end", A_NP, 0);
        settle();

        // three issues then reset asserted between edges
        for (int r = 1; r <= 3; r++) begin
            cyc();
            issue_a(r);
            settle();
        end
        cyc();
        idle_a(); ia.iss_valid = 1'b1; ia.rR1 = 5'd2;
        expect_v("three_np", A_NP, 3);
        expect_v("three_stall", A_STALL, 1);
        settle();
        #2 rst_n = 1'b0;
        #1;
        ia.rR2 = 5'd5;
        #1;
        expect_v("midrst_np", A_NP, 0);
        expect_v("midrst_stall", A_STALL, 0);
        expect_v("midrst_fire", A_FIRE, 1);
        expect_v("midrst_arr", A_RD2, 0);
        drain();
        cyc();
        rst_n = 1'b1;
        idle_a(); issue_a(4);
        expect_v("postrst_fire", A_FIRE, 1);
        settle();
        cyc();
        idle_a();
        expect_v("postrst_np", A_NP, 1);
        settle();

        // wide/shallow instance
        cyc();
        ib.we = 1'b1; ib.wR = 3'd7; ib.wD = 64'hFFFF_FFFF_FFFF_FFFF; ib.rR1 = 3'd7;
        expect_v("b_byp", B_RD1, 64'hFFFF_FFFF_FFFF_FFFF);
        settle();
        cyc();
        idle_b(); ib.rR1 = 3'd7; ib.rR2 = 3'd7;
        expect_v("b_rd1", B_RD1, 64'hFFFF_FFFF_FFFF_FFFF);
        expect_v("b_rd2", B_RD2, 64'hFFFF_FFFF_FFFF_FFFF);
        expect_v("b_np0", B_NP, 0);
        settle();
        for (int r = 1; r < 8; r++) begin
            cyc();
            ib.iss_valid = 1'b1; ib.iss_wen = 1'b1; ib.iss_rd = 3'(r);
            settle();
        end
        cyc();
        idle_b();
        expect_v("b_np_full", B_NP, 7);
        settle();
        cyc();
        ib.we = 1'b1; ib.wR = 3'd3; ib.wD = 64'h1;
        settle();
        cyc();
        idle_b();
        expect_v("b_np_dec", B_NP, 6);
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
